// File: rtl/id_symbol_feeder_pkg.sv
// Shared definitions for the ID symbol feeder: FSM state encoding, symbol width,
// default ID width and a counter-width helper.
package id_symbol_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SYM_W     = 2;
  localparam int DEF_WIDTH = 17;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/id_symbol_feeder_hold_timer.sv
// Counts HOLD cycles while enabled; term is high on the last cycle of each hold window.
module id_symbol_feeder_hold_timer
  import id_symbol_feeder_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic term
);

  localparam int HCW = cnt_w(HOLD);

  logic [HCW-1:0] hold_cnt;

  assign term = en && (hold_cnt == HCW'(HOLD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
    end else if (clr) begin
      hold_cnt <= '0;
    end else if (en) begin
      hold_cnt <= term ? '0 : hold_cnt + HCW'(1);
    end
  end

endmodule

// File: rtl/id_symbol_feeder.sv
// Loads a WIDTH-bit ID word on start and streams it MSB-first as 2-bit symbols,
// each held for HOLD cycles, followed by a one-cycle done pulse.
module id_symbol_feeder
  import id_symbol_feeder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] word,
  output logic [1:0]       a,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int NSYM = (WIDTH + 1) / 2;
  localparam int SW   = SYM_W * NSYM;
  localparam int PAD  = SW - WIDTH;
  localparam int SCW  = cnt_w(NSYM);

  state_t          state;
  logic [SW-1:0]   sreg;
  logic [SW-1:0]   word_ext;
  logic [SW-1:0]   sreg_next;
  logic [SCW-1:0]  sym_cnt;
  logic            hold_term;

  // Odd widths get a single zero pad bit below the LSB.
  assign word_ext  = SW'(word) << PAD;
  assign sreg_next = sreg << SYM_W;

  id_symbol_feeder_hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .en    (state == EMIT),
    .clr   (state == IDLE),
    .term  (hold_term)
  );

  // Outputs are set alongside the state transition so they are pure flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sreg    <= '0;
      sym_cnt <= '0;
      a       <= 2'b00;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= EMIT;
            sreg    <= word_ext;
            sym_cnt <= '0;
            a       <= word_ext[SW-1 -: 2];
            valid   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        EMIT: begin
          if (hold_term) begin
            if (sym_cnt == SCW'(NSYM - 1)) begin
              state <= DONE;
              a     <= 2'b00;
              valid <= 1'b0;
              done  <= 1'b1;
            end else begin
              sreg    <= sreg_next;
              sym_cnt <= sym_cnt + SCW'(1);
              a       <= sreg_next[SW-1 -: 2];
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          a     <= 2'b00;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
